// File: rtl/i_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID register.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i_fetch_stage_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Encodings are shared with the decode stage, so they are pinned explicitly.
  typedef enum logic {
    FETCH = 1'b0,
    STALL = 1'b1
  } fetch_state_e;

  localparam word_t NOP_INSTR_DEF = 32'h0000_0000;
  localparam word_t RESET_PC_DEF  = 32'h0000_0000;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    word_t instr;
    word_t npc;
    logic  valid;
  } ifid_t;

  // PC is a word address; the increment wraps silently at 2^32.
  function automatic word_t next_pc(input word_t pc);
    return pc + 32'd1;
  endfunction

endpackage

// File: rtl/i_fetch_stage_if.sv
// Instruction-memory read port: one word request per address, completed by ack.
// Latency: set by the memory; the requester holds imem_addr until imem_ack.
// Backpressure: the memory stalls the fetch by withholding imem_ack.
interface i_fetch_stage_if;
  import i_fetch_stage_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_ack;
  word_t imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/i_fetch_stage_if_id_reg.sv
// IF/ID pipeline register holding {instruction, npc, valid}; flush beats load beats hold.
// Latency: 1 cycle from load/flush to output.
// Backpressure: holds its contents whenever neither load nor flush is asserted.
module if_id_reg
  import i_fetch_stage_pkg::*;
#(
  parameter word_t NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  load,
  input  logic  flush,
  input  word_t instr_in,
  input  word_t npc_in,
  output ifid_t ifid_out
);

  ifid_t ifid_d;
  ifid_t ifid_q;

  // Select the next register contents: a bubble, a new instruction, or the current one.
  always_comb begin
    ifid_d = ifid_q;
    if (flush) begin
      ifid_d = '{instr: NOP_INSTR, npc: '0, valid: 1'b0};
    end else if (load) begin
      ifid_d = '{instr: instr_in, npc: npc_in, valid: 1'b1};
    end
  end

  // Register update; reset leaves a bubble in the stage.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ifid_q <= '{instr: NOP_INSTR, npc: '0, valid: 1'b0};
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign ifid_out = ifid_q;

endmodule

// File: rtl/i_fetch_stage.sv
// Instruction fetch: owns the PC, reads imem over req/ack, fills IF/ID; redirects flush IF/ID.
// Latency: 1 cycle from accepted imem word to IF/ID; 1 instr/cycle with zero-wait memory.
// Backpressure: PCWrite/IFIDWrite low parks an accepted word in hold_buf and drops imem_req.
module i_fetch_stage
  import i_fetch_stage_pkg::*;
#(
  parameter word_t RESET_PC  = RESET_PC_DEF,
  parameter word_t NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     PCWrite,
  input  logic                     IFIDWrite,
  input  logic                     branchTaken,
  input  word_t                    branch_target,
  input  logic                     jumpTaken,
  input  word_t                    jump_target,
  i_fetch_stage_if.master          imem,
  output word_t                    instruction_out,
  output word_t                    npc_out,
  output logic                     valid_out
);

  fetch_state_e state_d, state_q;
  word_t        pc_d, pc_q;
  word_t        hold_buf_d, hold_buf_q;
  word_t        redir_pc_d, redir_pc_q;
  logic         redirect_pend_d, redirect_pend_q;
  logic         imem_req_d, imem_req_q;

  logic         accept;
  logic         redirect;
  word_t        redirect_target;
  logic         ifid_load;
  logic         ifid_flush;
  word_t        ifid_instr;
  ifid_t        ifid;

  // An ack only counts against a request we actually issued, so a late ack after reset is ignored.
  assign accept          = imem.imem_ack & imem_req_q;
  assign redirect        = jumpTaken | branchTaken;
  assign redirect_target = jumpTaken ? jump_target : branch_target;

  // Next-state logic for the PC, the fetch FSM and the IF/ID load/flush controls.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    hold_buf_d      = hold_buf_q;
    redir_pc_d      = redir_pc_q;
    redirect_pend_d = redirect_pend_q;
    ifid_load       = 1'b0;
    ifid_flush      = 1'b0;
    ifid_instr      = imem.imem_rdata;

    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          // The in-flight word is on the wrong path; if it has not returned yet,
          // keep the address stable and remember where to go once it does.
          ifid_flush = 1'b1;
          if (accept) begin
            pc_d            = redirect_target;
            redirect_pend_d = 1'b0;
          end else begin
            redir_pc_d      = redirect_target;
            redirect_pend_d = 1'b1;
          end
        end else if (accept && redirect_pend_q) begin
          ifid_flush      = 1'b1;
          pc_d            = redir_pc_q;
          redirect_pend_d = 1'b0;
        end else if (accept && PCWrite && IFIDWrite) begin
          ifid_load = 1'b1;
          pc_d      = next_pc(pc_q);
        end else if (accept) begin
          // Decode is stalled: park the word and stop requesting until released.
          hold_buf_d = imem.imem_rdata;
          state_d    = STALL;
          ifid_flush = IFIDWrite;
        end else begin
          ifid_flush = IFIDWrite;
        end
      end
      STALL: begin
        ifid_instr = hold_buf_q;
        if (redirect) begin
          ifid_flush = 1'b1;
          pc_d       = redirect_target;
          state_d    = FETCH;
        end else if (PCWrite && IFIDWrite) begin
          ifid_load = 1'b1;
          pc_d      = next_pc(pc_q);
          state_d   = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    imem_req_d = (state_d == FETCH);
  end

  // State and registered-output update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q         <= FETCH;
      pc_q            <= RESET_PC;
      hold_buf_q      <= '0;
      redir_pc_q      <= '0;
      redirect_pend_q <= 1'b0;
      imem_req_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      hold_buf_q      <= hold_buf_d;
      redir_pc_q      <= redir_pc_d;
      redirect_pend_q <= redirect_pend_d;
      imem_req_q      <= imem_req_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .CLK      (CLK),
    .RST      (RST),
    .load     (ifid_load),
    .flush    (ifid_flush),
    .instr_in (ifid_instr),
    .npc_in   (next_pc(pc_q)),
    .ifid_out (ifid)
  );

  assign imem.imem_req   = imem_req_q;
  assign imem.imem_addr  = pc_q;
  assign instruction_out = ifid.instr;
  assign npc_out         = ifid.npc;
  assign valid_out       = ifid.valid;

endmodule
